// File: rtl/up_down_count_monitor.sv
// Observer for a WIDTH-bit up/down counter stream: direction lock, jump/wrap/reversal
// detection and statistics. Optional synchronous clear port under UP_DOWN_MON_CLEAR_EN.
module up_down_count_monitor #(
  parameter int unsigned WIDTH    = 4,
  parameter int unsigned STAT_W   = 8,
  parameter int unsigned LOCK_LEN = 2
) (
  input  logic              clk,
  input  logic              reset,
`ifdef UP_DOWN_MON_CLEAR_EN
  input  logic              clear,
`endif
  input  logic              sample_valid,
  input  logic [WIDTH-1:0]  count_in,
  output logic [1:0]        state,
  output logic              dir_valid,
  output logic              dir_up,
  output logic              step_err,
  output logic              rev_pulse,
  output logic              wrap_pulse,
  output logic [STAT_W-1:0] err_count,
  output logic [STAT_W-1:0] wrap_count
);

  typedef enum logic [1:0] {
    StSeek     = 2'b00,
    StLockUp   = 2'b01,
    StLockDown = 2'b10,
    StErr      = 2'b11
  } state_e;

  state_e           state_q;
  logic [WIDTH-1:0] prev_q;
  logic             has_prev_q;
  logic [3:0]       run_q;
  logic             run_dir_q;

  logic [WIDTH-1:0] delta;
  logic             is_hold, is_up, is_down, is_jump, is_wrap;
  logic [4:0]       run_inc;
  logic             clr;

`ifdef UP_DOWN_MON_CLEAR_EN
  assign clr = clear;
`else
  assign clr = 1'b0;
`endif

  assign state = state_q;

  always_comb begin
    delta   = count_in - prev_q;
    is_hold = (delta == '0);
    is_up   = (delta == WIDTH'(1));
    is_down = (delta == '1);
    is_jump = !(is_hold || is_up || is_down);
    is_wrap = (is_up && (prev_q == '1)) || (is_down && (prev_q == '0));
    run_inc = {1'b0, run_q} + 5'd1;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q    <= StSeek;
      prev_q     <= '0;
      has_prev_q <= 1'b0;
      run_q      <= '0;
      run_dir_q  <= 1'b0;
      dir_valid  <= 1'b0;
      dir_up     <= 1'b0;
      step_err   <= 1'b0;
      rev_pulse  <= 1'b0;
      wrap_pulse <= 1'b0;
      err_count  <= '0;
      wrap_count <= '0;
    end else begin
      step_err   <= 1'b0;
      rev_pulse  <= 1'b0;
      wrap_pulse <= 1'b0;
      if (clr) begin
        state_q    <= StSeek;
        has_prev_q <= 1'b0;
        run_q      <= '0;
        dir_valid  <= 1'b0;
        dir_up     <= 1'b0;
        err_count  <= '0;
        wrap_count <= '0;
      end else if (sample_valid) begin
        prev_q     <= count_in;
        has_prev_q <= 1'b1;
        // The first sample after reset/clear only seeds prev.
        if (has_prev_q && !is_hold) begin
          if (is_wrap) begin
            wrap_pulse <= 1'b1;
            wrap_count <= wrap_count + 1'b1;
          end
          if (is_jump) begin
            step_err  <= 1'b1;
            if (err_count != '1) err_count <= err_count + 1'b1;
            run_q     <= '0;
            state_q   <= StErr;
            dir_valid <= 1'b0;
            dir_up    <= 1'b0;
          end else begin
            unique case (state_q)
              StSeek: begin
                if ((run_q != '0) && (run_dir_q == is_up)) begin
                  run_q <= run_inc[3:0];
                  if (run_inc >= 5'(LOCK_LEN)) begin
                    state_q   <= is_up ? StLockUp : StLockDown;
                    dir_valid <= 1'b1;
                    dir_up    <= is_up;
                  end
                end else begin
                  run_q     <= 4'd1;
                  run_dir_q <= is_up;
                  if (LOCK_LEN <= 1) begin
                    state_q   <= is_up ? StLockUp : StLockDown;
                    dir_valid <= 1'b1;
                    dir_up    <= is_up;
                  end
                end
              end
              StLockUp, StLockDown: begin
                if (is_up != (state_q == StLockUp)) begin
                  rev_pulse <= 1'b1;
                  state_q   <= StSeek;
                  run_q     <= 4'd1;
                  run_dir_q <= is_up;
                  dir_valid <= 1'b0;
                  dir_up    <= 1'b0;
                end
              end
              StErr: begin
                state_q   <= StSeek;
                run_q     <= 4'd1;
                run_dir_q <= is_up;
              end
            endcase
          end
        end
      end
    end
  end

endmodule

// File: tb/tb_up_down_count_monitor.sv
// Directed bench for up_down_count_monitor with a queue scoreboard fed by a reference model.
module tb_up_down_count_monitor;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       sample_valid = 1'b0;
  logic [3:0] count_in = '0;
`ifdef UP_DOWN_MON_CLEAR_EN
  logic       clear = 1'b0;
`endif
  logic [1:0] state;
  logic       dir_valid, dir_up, step_err, rev_pulse, wrap_pulse;
  logic [7:0] err_count, wrap_count;

  up_down_count_monitor dut (
    .clk         (clk),
    .reset       (reset),
`ifdef UP_DOWN_MON_CLEAR_EN
    .clear       (clear),
`endif
    .sample_valid(sample_valid),
    .count_in    (count_in),
    .state       (state),
    .dir_valid   (dir_valid),
    .dir_up      (dir_up),
    .step_err    (step_err),
    .rev_pulse   (rev_pulse),
    .wrap_pulse  (wrap_pulse),
    .err_count   (err_count),
    .wrap_count  (wrap_count)
  );

  always #5 clk = ~clk;

  typedef struct {
    int st;
    int se;
    int rp;
    int wp;
    int err;
    int wrap;
  } exp_t;

  exp_t sb[$];
  int   n_tests = 0;
  int   n_fail  = 0;

  // Reference model state
  int m_state, m_run, m_dir, m_prev, m_has, m_err, m_wrap, m_se, m_rp, m_wp;

  task automatic model_reset();
    m_state = 0; m_run = 0; m_dir = 0; m_prev = 0; m_has = 0;
    m_err = 0; m_wrap = 0; m_se = 0; m_rp = 0; m_wp = 0;
  endtask

  task automatic model_step(input int v, input int c);
    int d, p, up;
    m_se = 0; m_rp = 0; m_wp = 0;
    if (v == 0) return;
    if (m_has == 0) begin
      m_prev = c; m_has = 1;
      return;
    end
    d = (c - m_prev) & 15;
    p = m_prev;
    m_prev = c;
    if (d == 0) return;
    if (d != 1 && d != 15) begin
      m_se = 1;
      if (m_err < 255) m_err++;
      m_run = 0;
      m_state = 3;
      return;
    end
    up = (d == 1) ? 1 : 0;
    if ((up == 1 && p == 15) || (up == 0 && p == 0)) begin
      m_wp = 1;
      m_wrap = (m_wrap + 1) % 256;
    end
    if (m_state == 0) begin
      if (m_run > 0 && m_dir == up) m_run++;
      else begin m_run = 1; m_dir = up; end
      if (m_run >= 2) m_state = up ? 1 : 2;
    end else if (m_state == 3) begin
      m_state = 0; m_run = 1; m_dir = up;
    end else if (up != ((m_state == 1) ? 1 : 0)) begin
      m_rp = 1; m_state = 0; m_run = 1; m_dir = up;
    end
  endtask

  task automatic chk(input string tag, input int obs, input int expv);
    n_tests++;
    assert (obs === expv) else begin
      n_fail++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, expv);
    end
  endtask

  task automatic compare_out();
    exp_t e;
    if (sb.size() == 0) begin
      chk("sb_empty", 0, 1);
      return;
    end
    e = sb.pop_front();
    chk("state", int'(state), e.st);
    chk("dir_valid", int'(dir_valid), (e.st == 1 || e.st == 2) ? 1 : 0);
    chk("dir_up", int'(dir_up), (e.st == 1) ? 1 : 0);
    chk("step_err", int'(step_err), e.se);
    chk("rev_pulse", int'(rev_pulse), e.rp);
    chk("wrap_pulse", int'(wrap_pulse), e.wp);
    chk("err_count", int'(err_count), e.err);
    chk("wrap_count", int'(wrap_count), e.wrap);
  endtask

  task automatic step(input int v, input int c);
    exp_t e;
    model_step(v, c);
    e.st = m_state; e.se = m_se; e.rp = m_rp; e.wp = m_wp; e.err = m_err; e.wrap = m_wrap;
    sb.push_back(e);
    sample_valid = (v != 0);
    count_in = 4'(c);
    @(posedge clk);
    #1;
    compare_out();
  endtask

  task automatic do_reset();
    reset = 1'b1;
    #1;
    chk("rst_state", int'(state), 0);
    chk("rst_flags", int'({dir_valid, dir_up, step_err, rev_pulse, wrap_pulse}), 0);
    chk("rst_counts", int'({err_count, wrap_count}), 0);
    model_reset();
    sb.delete();
    @(posedge clk);
    #1;
    reset = 1'b0;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL timeout observed=running expected=finished");
    $fatal(1, "timeout");
  end

  initial begin
    model_reset();
    do_reset();

    // 1: lock up
    step(1, 0); step(1, 1);
    chk("t1_seek_after_1", int'(state), 0);
    step(1, 2);
    chk("t1_lock_after_2", int'(state), 1);
    step(1, 3);
    chk("t1_err0", int'(err_count), 0);

    // 2: wrap while locked up
    for (int i = 4; i <= 15; i++) step(1, i);
    step(1, 0);
    chk("t2_wrap_pulse", int'(wrap_pulse), 1);
    chk("t2_wrap_count", int'(wrap_count), 1);
    step(1, 1);
    chk("t2_wrap_once", int'(wrap_pulse), 0);
    chk("t2_still_up", int'(state), 1);

    // 3: down lock, reversal, up lock (1->9 is a jump)
    step(1, 9); step(1, 8); step(1, 7);
    chk("t3_lock_down", int'(state), 2);
    step(1, 8);
    chk("t3_rev", int'(rev_pulse), 1);
    chk("t3_rev_seek", int'(state), 0);
    step(1, 9);
    chk("t3_relock_up", int'(state), 1);

    // 4: jumps from lock
    do_reset();
    step(1, 2); step(1, 3); step(1, 4);
    step(1, 9);
    chk("t4_step_err", int'(step_err), 1);
    chk("t4_err1", int'(err_count), 1);
    chk("t4_state_err", int'(state), 3);
    step(1, 12);
    chk("t4_err2", int'(err_count), 2);
    step(1, 13);
    chk("t4_seek", int'(state), 0);

    // 5: holds and idle cycles, then mid-run reset
    do_reset();
    step(1, 5); step(1, 6); step(1, 7);
    step(1, 7); step(1, 7);
    for (int i = 0; i < 5; i++) step(0, int'($urandom_range(0, 15)));
    step(1, 8);
    chk("t5_still_up", int'(state), 1);
    do_reset();
    step(1, 3);
    chk("t5_first_sample", int'(state), 0);
    step(1, 4);
    chk("t5_no_pulse", int'({step_err, wrap_pulse}), 0);

    // 6: saturate err_count, wrap wrap_count
    do_reset();
    for (int i = 0; i < 300; i++) step(1, (i % 2 == 0) ? 0 : 8);
    chk("t6_err_sat", int'(err_count), 255);
    for (int k = 1; k <= 4160; k++) step(1, (8 + k) & 15);
    chk("t6_wrap_mod", int'(wrap_count), 4);
    chk("t6_err_held", int'(err_count), 255);

`ifdef UP_DOWN_MON_CLEAR_EN
    clear = 1'b1;
    sample_valid = 1'b1;
    count_in = 4'd5;
    @(posedge clk);
    #1;
    clear = 1'b0;
    sample_valid = 1'b0;
    chk("clr_err", int'(err_count), 0);
    chk("clr_wrap", int'(wrap_count), 0);
    chk("clr_state", int'(state), 0);
`endif

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/up_down_count_monitor.md
Name: up_down_count_monitor

Overview:
Observer for the team's 4-bit synchronous up/down counter bus. It samples a count stream and works out the count direction. It also flags illegal steps (jumps), detects wrap-around and direction reversals, and keeps saturating error and wrapping wrap statistics. It sits on the reader side of any counter output, for self-check and debug, and is fully registered.

Parameters:
WIDTH, 4, width of the observed count bus
STAT_W, 8, width of err_count and wrap_count
LOCK_LEN, 2, consecutive same-direction steps needed to lock direction (range 1 to 15)

Ports:
clk  input  1  clock, rising edge
reset  input  1  asynchronous, active-high reset
sample_valid  input  1  count_in is sampled on this cycle when high
count_in  input  WIDTH  observed counter value
state  output  2  FSM state: 00 SEEK, 01 LOCK_UP, 10 LOCK_DOWN, 11 ERR
dir_valid  output  1  high in LOCK_UP or LOCK_DOWN
dir_up  output  1  1 = up, 0 = down; meaningful only while dir_valid is high
step_err  output  1  one-cycle pulse on an illegal jump
rev_pulse  output  1  one-cycle pulse on a direction reversal from a locked state
wrap_pulse  output  1  one-cycle pulse on a wrap: up step max->0 or down step 0->max
err_count  output  STAT_W  illegal-jump count; saturates at all-ones
wrap_count  output  STAT_W  wrap-event count; wraps modulo 2^STAT_W

Behaviour:
- Reset (asynchronous, active-high; clock clk): all outputs go to 0, state goes to SEEK, the has_prev flag clears, and the run counter clears. Reset applied mid-sequence discards the held previous sample.
- sample_valid low: no internal state changes and all pulses are 0 on the next cycle. count_in is ignored.
- First valid sample after reset (has_prev = 0): store it as prev, set has_prev, produce no classification and no pulses.
- Each later valid sample: compute delta = (count_in - prev) mod 2^WIDTH, classify it, then set prev = count_in.
- Classification:
  - delta = 0 is HOLD.
  - delta = 1 is UP.
  - delta = all-ones is DOWN.
  - Any other delta is JUMP.
- Latency: every output reflects a sample on the clock edge that samples it, so outputs are visible in the following cycle. Pulses last exactly one cycle.
- HOLD: no state change, no pulses, run counter unchanged.
- Wrap: an UP step from all-ones to 0, or a DOWN step from 0 to all-ones, raises wrap_pulse and increments wrap_count in every state, including SEEK and ERR.
- SEEK:
  - UP or DOWN in the same direction as run_dir increments run; a change of direction sets run = 1 and run_dir to the new direction.
  - When run reaches LOCK_LEN, go to LOCK_UP or LOCK_DOWN. With LOCK_LEN = 1, the first step locks.
  - JUMP goes to ERR.
- LOCK_UP / LOCK_DOWN:
  - A step in the locked direction stays in the state.
  - An opposite step pulses rev_pulse, goes to SEEK with run = 1 and run_dir = the new direction, and sets dir_valid = 0.
  - JUMP goes to ERR.
- ERR: a non-JUMP step (UP or DOWN) goes to SEEK with run = 1 in that direction. JUMP stays in ERR.
- Every JUMP in any state: pulse step_err, increment err_count (saturating), clear run.
- Simultaneous events: the wrap check and the direction-reversal check are evaluated on the same sample, so wrap_pulse and rev_pulse can both assert on one cycle. A JUMP never raises wrap_pulse.

Optional Feature:
Macro UP_DOWN_MON_CLEAR_EN.
- Defined: adds input port clear (1 bit, synchronous, active-high). When clear is high it zeroes err_count and wrap_count, goes to SEEK, clears has_prev and run, and forces all pulses to 0. clear takes priority over a sample on the same cycle.
- Not defined: the port is absent and the statistics are cleared only by reset.

Test Plan:
1. Reset, then valid samples 0,1,2,3 on consecutive cycles -> state = LOCK_UP (dir_valid = 1, dir_up = 1) after the third sample (value 2); err_count = 0 and no pulses.
2. Locked up, samples 14,15,0,1 -> wrap_pulse high for exactly one cycle after 0 is sampled; wrap_count = 1; state stays LOCK_UP.
3. Samples 9,8,7 -> LOCK_DOWN, dir_up = 0; then sample 8 -> rev_pulse for one cycle, state = SEEK, dir_valid = 0; then sample 9 -> LOCK_UP.
4. Locked up at 4, sample 9 -> step_err pulse, err_count = 1, state = ERR; sample 12 -> err_count = 2, still ERR; sample 13 -> SEEK.
5. Locked up at 7, samples 7,7 with sample_valid high, then sample_valid low with count_in toggling randomly for 5 cycles, then sample 8 -> no pulses and stays LOCK_UP throughout. Assert reset mid-run -> all outputs 0 immediately, and the next sample is treated as a first sample.
6. 300 consecutive jump samples (alternating 0 and 8) -> err_count saturates at 255, while wrap_count is driven past 255 with 260 up-wraps and reads 4. With UP_DOWN_MON_CLEAR_EN defined, one clear cycle -> both counts = 0 and state = SEEK.
